load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory execution stage directly downstream of the reservation station's memory port.
- Takes one issued load/store (op, base, store data, immediate, destination tag) and computes the effective address as base + imm.
- Performs the access over a byte-serial synchronous RAM interface, little-endian.
- Returns the result and tag on the memory broadcast bus that the reservation station snoops.

Parameters:
- ADDR_WIDTH, 32, width of mem_a; the effective address is truncated to its low ADDR_WIDTH bits.
- NOP_OP, 5'b11111, op encoding meaning "no instruction issued".

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pause  input  1  global stall; when 1, all state is frozen.
- op  input  5  memory opcode: LB=10010, LH=10011, LW=10100, LBU=10101, LHU=10110, SB=10111, SH=11000, SW=11001, NOP_OP = none.
- value1  input  32  base register value.
- value2  input  32  store data.
- imm  input  32  sign-extended offset.
- des  input  3  destination tag; 0 = no tag.
- ready  output  1  combinational, 1 when state==IDLE; issue is accepted only while ready=1.
- mem_a  output  ADDR_WIDTH  RAM byte address.
- mem_wr  output  1  RAM write enable.
- mem_dout  output  8  RAM write byte.
- mem_din  input  8  RAM read byte; valid one cycle after its address is presented.
- result_data  output  32  load result (0 for stores).
- result_des  output  3  completion tag; nonzero for exactly one cycle per completed op.

Behaviour:
- Reset values (async, immediate): state=IDLE, mem_a=0, mem_wr=0, mem_dout=0, result_data=0, result_des=0, byte counter=0, latched op/addr/data/des=0.
- Reset mid-access aborts the access: mem_wr drops immediately, no completion is reported, remaining bytes are never written.
- pause=1: no register changes, except that mem_wr is forced to 0 combinationally. An op presented during pause is not accepted. Resuming continues exactly where the access stopped.
- Byte count N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- Effective address EA = value1 + imm, modulo 2^32, then truncated to ADDR_WIDTH bits.
- Byte addresses EA+k also wrap modulo 2^ADDR_WIDTH.
- States: IDLE, LOAD, STORE.
- IDLE: at edge T0, if op != NOP_OP, op is a memory opcode, and pause=0:
  - Latch op, EA, value2 and des.
  - Set mem_a=EA and clear result_des to 0.
  - Load: go to LOAD, mem_wr=0.
  - Store: go to STORE, mem_wr=1, mem_dout=value2[7:0].
  - Non-memory opcodes (other than NOP_OP) are ignored; stay in IDLE.
- LOAD, at edge Tk (k=1..N):
  - Capture mem_din into assembly byte k-1.
  - If k<N, mem_a=EA+k.
  - At k=N: result_data = assembled value, result_des = latched des, state=IDLE.
  - Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW takes 32 bits.
- STORE, at edge Tk (k=1..N):
  - If k<N: mem_a=EA+k, mem_dout=value2[8k+7:8k], mem_wr stays 1.
  - At k=N: mem_wr=0, result_data=0, result_des=des, state=IDLE.
  - Exactly N RAM writes occur per store.
- Latency: completion is visible after edge T0+N for every op.
- result_des returns to 0 at the next edge unless a new completion occurs.
- Throughput: the next op can be accepted at edge T0+N+1 at the earliest, i.e. N+1 cycles per op.
- An op presented while ready=0 is dropped; the upstream stage must hold it until ready=1.
- des=0: the access is still performed fully; result_des stays 0.

Test Plan:
- LW: RAM[0x100..0x103]=0x78,0x56,0x34,0x12; issue LW value1=0x0FC, imm=4, des=3 at T0 -> mem_a sequence 0x100..0x103, mem_wr=0 throughout, after T4 result_data=0x12345678 and result_des=3 for one cycle, ready=1 in that cycle.
- LB/LBU: RAM[0x20]=0x80 -> LB gives 0xFFFFFF80 after 1 cycle; LBU gives 0x00000080; LH over 0x80,0xFF gives 0xFFFFFF80.
- SW then LW: SW value1=0x200, imm=-4, value2=0xDEADBEEF, des=5 -> writes 0xEF,0xBE,0xAD,0xDE to 0x1FC..0x1FF, mem_wr high exactly 4 cycles, result_des=5 and result_data=0 after T4; a following LW from 0x1FC returns 0xDEADBEEF.
- Pause: assert pause for 3 cycles after byte 1 of an SH -> mem_wr=0 and mem_a held during pause; after release the second byte is written once and completion occurs 3 cycles later than nominal.
- Reset mid-SW after 2 bytes -> mem_wr=0 immediately, result_des stays 0, bytes 2 and 3 are unchanged in RAM, ready=1 after reset.
- Wrap and busy: with ADDR_WIDTH=17, LH at EA=0x1FFFF reads 0x1FFFF then 0x00000; an op presented while ready=0 produces no access and no completion.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory execution stage: computes base+imm, runs a byte-serial little-endian
// load or store over a synchronous RAM port, then broadcasts result and tag.
module load_store_unit #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [4:0] NOP_OP     = 5'b11111
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause,
  input  logic [4:0]            op,
  input  logic [31:0]           value1,
  input  logic [31:0]           value2,
  input  logic [31:0]           imm,
  input  logic [2:0]            des,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din,
  output logic [31:0]           result_data,
  output logic [2:0]            result_des
);

  localparam logic [4:0] OP_LB  = 5'b10010;
  localparam logic [4:0] OP_LH  = 5'b10011;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_LBU = 5'b10101;
  localparam logic [4:0] OP_LHU = 5'b10110;
  localparam logic [4:0] OP_SB  = 5'b10111;
  localparam logic [4:0] OP_SW  = 5'b11001;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;

  state_t                r_state;
  logic [4:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [31:0]           r_data;
  logic [31:0]           r_asm;
  logic [31:0]           r_result_data;
  logic [2:0]            r_des;
  logic [2:0]            r_result_des;
  logic [2:0]            r_cnt;
  logic                  r_mem_wr;
  logic [7:0]            r_mem_dout;

  logic                  w_accept;
  logic                  w_is_store;
  logic [ADDR_WIDTH-1:0] w_ea;
  logic [2:0]            w_n;
  logic [2:0]            w_next_cnt;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [31:0]           w_asm;
  logic [31:0]           w_load_result;
  logic [7:0]            w_store_byte;

  function automatic logic [2:0] byte_count(input logic [4:0] f_op);
    case (f_op)
      OP_LB, OP_LBU, OP_SB:  byte_count = 3'd1;
      OP_LW, OP_SW:          byte_count = 3'd4;
      default:               byte_count = 3'd2;
    endcase
  endfunction

  // NOP_OP is checked explicitly so a re-encoded NOP inside the range is still ignored.
  assign w_accept    = (op != NOP_OP) && (op >= OP_LB) && (op <= OP_SW);
  assign w_is_store  = (op >= OP_SB) && (op <= OP_SW);
  assign w_ea        = ADDR_WIDTH'(value1 + imm);
  assign w_n         = byte_count(r_op);
  assign w_next_cnt  = r_cnt + 3'd1;
  assign w_last      = (w_next_cnt == w_n);
  assign w_next_addr = r_addr + ADDR_WIDTH'(w_next_cnt);
  assign w_store_byte = r_data[{w_next_cnt[1:0], 3'b000} +: 8];

  // Incoming byte merged into its lane so the final byte is usable on the completing edge.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_asm[8*gi +: 8] = (r_cnt == 3'(gi)) ? mem_din : r_asm[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_load_result = w_asm;
    case (r_op)
      OP_LB:   w_load_result = {{24{w_asm[7]}}, w_asm[7:0]};
      OP_LBU:  w_load_result = {24'd0, w_asm[7:0]};
      OP_LH:   w_load_result = {{16{w_asm[15]}}, w_asm[15:0]};
      OP_LHU:  w_load_result = {16'd0, w_asm[15:0]};
      default: w_load_result = w_asm;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= 5'd0;
      r_addr        <= '0;
      r_mem_a       <= '0;
      r_data        <= 32'd0;
      r_asm         <= 32'd0;
      r_result_data <= 32'd0;
      r_des         <= 3'd0;
      r_result_des  <= 3'd0;
      r_cnt         <= 3'd0;
      r_mem_wr      <= 1'b0;
      r_mem_dout    <= 8'd0;
    end else if (!pause) begin
      case (r_state)
        S_IDLE: begin
          r_result_des <= 3'd0;
          if (w_accept) begin
            r_op    <= op;
            r_addr  <= w_ea;
            r_data  <= value2;
            r_des   <= des;
            r_mem_a <= w_ea;
            r_cnt   <= 3'd0;
            r_asm   <= 32'd0;
            if (w_is_store) begin
              r_state    <= S_STORE;
              r_mem_wr   <= 1'b1;
              r_mem_dout <= value2[7:0];
            end else begin
              r_state  <= S_LOAD;
              r_mem_wr <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          r_asm <= w_asm;
          if (w_last) begin
            r_result_data <= w_load_result;
            r_result_des  <= r_des;
            r_cnt         <= 3'd0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt   <= w_next_cnt;
            r_mem_a <= w_next_addr;
          end
        end
        S_STORE: begin
          if (w_last) begin
            r_mem_wr      <= 1'b0;
            r_result_data <= 32'd0;
            r_result_des  <= r_des;
            r_cnt         <= 3'd0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt      <= w_next_cnt;
            r_mem_a    <= w_next_addr;
            r_mem_dout <= w_store_byte;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign mem_a       = r_mem_a;
  assign mem_wr      = r_mem_wr & ~pause;
  assign mem_dout    = r_mem_dout;
  assign result_data = r_result_data;
  assign result_des  = r_result_des;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized ops checked
// against a byte-array memory model and arithmetic expectations.
module tb_load_store_unit;

  localparam int AW     = 17;
  localparam int MEM_SZ = 1 << AW;

  localparam logic [4:0] LB  = 5'b10010;
  localparam logic [4:0] LH  = 5'b10011;
  localparam logic [4:0] LW  = 5'b10100;
  localparam logic [4:0] LBU = 5'b10101;
  localparam logic [4:0] LHU = 5'b10110;
  localparam logic [4:0] SB  = 5'b10111;
  localparam logic [4:0] SH  = 5'b11000;
  localparam logic [4:0] SW  = 5'b11001;
  localparam logic [4:0] NOP = 5'b11111;

  logic          clk = 1'b0;
  logic          rst;
  logic          pause;
  logic [4:0]    op;
  logic [31:0]   value1, value2, imm;
  logic [2:0]    des;
  logic          ready;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din;
  logic [31:0]   result_data;
  logic [2:0]    result_des;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;
  int cyc      = 0;

  logic [7:0] ram [0:MEM_SZ-1];
  logic [7:0] mdl [0:MEM_SZ-1];

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .pause(pause), .op(op),
    .value1(value1), .value2(value2), .imm(imm), .des(des),
    .ready(ready), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .result_data(result_data), .result_des(result_des)
  );

  always #5 clk = ~clk;

  // RAM: read data for the address presented is ready by the next edge.
  assign mem_din = ram[mem_a];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) begin
      ram[mem_a] <= mem_dout;
      wr_count   <= wr_count + 1;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int nbytes(input logic [4:0] o);
    if (o == LB || o == LBU || o == SB) return 1;
    if (o == LH || o == LHU || o == SH) return 2;
    return 4;
  endfunction

  // Issue one op at max rate, step through its access and check completion.
  task automatic run_op(input logic [4:0] o, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] im, input logic [2:0] d,
                        input int pause_after, input bit inject);
    int n;
    bit st;
    int wr0;
    int c0;
    int lat;
    logic [AW-1:0] ea;
    logic [31:0] expv;
    n    = nbytes(o);
    st   = (o == SB || o == SH || o == SW);
    ea   = AW'(v1 + im);
    expv = 32'd0;
    lat  = n + ((pause_after > 0 && pause_after < n) ? 3 : 0);
    if (st) begin
      for (int k = 0; k < n; k++) mdl[AW'(ea + AW'(k))] = 8'(v2 >> (8 * k));
    end else begin
      for (int k = 0; k < n; k++) expv = expv | (32'(mdl[AW'(ea + AW'(k))]) << (8 * k));
      if (o == LB && expv[7])  expv = expv | 32'hFFFF_FF00;
      if (o == LH && expv[15]) expv = expv | 32'hFFFF_0000;
    end
    @(negedge clk);
    check_value("ready_before_issue", ready, 1);
    op = o; value1 = v1; value2 = v2; imm = im; des = d;
    wr0 = wr_count;
    @(posedge clk); #1;
    c0 = cyc;
    if (inject) begin
      op = SB; value1 = 32'h1000; value2 = 32'h5A; imm = 0; des = 3'd7;
    end else begin
      op = NOP;
    end
    check_value("des_clear_at_issue", result_des, 0);
    for (int k = 1; k <= n; k++) begin
      if (pause_after > 0 && k - 1 == pause_after) begin
        pause = 1'b1;
        #1;
        for (int p = 0; p < 3; p++) begin
          check_value("pause_wr_low", mem_wr, 0);
          check_value("pause_addr_hold", mem_a, AW'(ea + AW'(k - 1)));
          @(posedge clk); #1;
        end
        pause = 1'b0;
        #1;
      end
      check_value("step_addr", mem_a, AW'(ea + AW'(k - 1)));
      check_value("step_wr", mem_wr, st);
      if (st) check_value("step_dout", mem_dout, 8'(v2 >> (8 * (k - 1))));
      check_value("step_busy", ready, 0);
      check_value("step_no_des", result_des, 0);
      @(posedge clk); #1;
    end
    check_value("done_des", result_des, d);
    check_value("done_data", result_data, expv);
    check_value("done_ready", ready, 1);
    check_value("write_count", wr_count - wr0, st ? n : 0);
    check_value("latency", cyc - c0, lat);
    if (inject) op = NOP;
    $display("op=%b ea=0x%05h data=0x%08h des=%0d lat=%0d", o, ea, result_data, result_des, cyc - c0);
  endtask

  // Non-memory opcode: must be ignored entirely.
  task automatic idle_op(input logic [4:0] o);
    logic [AW-1:0] a0;
    int wr0;
    @(negedge clk);
    a0 = mem_a; wr0 = wr_count;
    op = o; value1 = $urandom; imm = 0; des = 3'd4;
    @(posedge clk); #1;
    op = NOP;
    check_value("ignored_ready", ready, 1);
    check_value("ignored_des", result_des, 0);
    check_value("ignored_addr", mem_a, a0);
    check_value("ignored_writes", wr_count - wr0, 0);
    $display("op=%b ignored", o);
  endtask

  initial begin
    logic [4:0] ro;
    int sel;
    rst = 1'b1; pause = 1'b0; op = NOP; value1 = 0; value2 = 0; imm = 0; des = 0;
    #1;
    check_value("rst_ready", ready, 1);
    check_value("rst_mem_a", mem_a, 0);
    check_value("rst_mem_wr", mem_wr, 0);
    check_value("rst_dout", mem_dout, 0);
    check_value("rst_data", result_data, 0);
    check_value("rst_des", result_des, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // LW assembly
    run_op(SW, 32'h100, 32'h1234_5678, 0, 3'd1, 0, 0);
    run_op(LW, 32'h0FC, 0, 4, 3'd3, 0, 0);
    check_value("lw_const", result_data, 32'h1234_5678);

    // sign / zero extension
    run_op(SH, 32'h20, 32'h0000_FF80, 0, 3'd1, 0, 0);
    run_op(LB, 32'h20, 0, 0, 3'd2, 0, 0);
    check_value("lb_const", result_data, 32'hFFFF_FF80);
    run_op(LBU, 32'h20, 0, 0, 3'd2, 0, 0);
    check_value("lbu_const", result_data, 32'h0000_0080);
    run_op(LH, 32'h20, 0, 0, 3'd2, 0, 0);
    check_value("lh_const", result_data, 32'hFFFF_FF80);

    // store then reload with negative offset
    run_op(SW, 32'h200, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 3'd5, 0, 0);
    run_op(LW, 32'h1FC, 0, 0, 3'd6, 0, 0);
    check_value("sw_lw_const", result_data, 32'hDEAD_BEEF);

    // pause after first SH byte
    run_op(SH, 32'h300, 32'h0000_A1B2, 0, 3'd2, 1, 0);
    run_op(LHU, 32'h300, 0, 0, 3'd1, 0, 0);
    check_value("pause_sh_const", result_data, 32'h0000_A1B2);

    // reset during a SW after two bytes
    run_op(SW, 32'h400, 32'h4433_2211, 0, 3'd1, 0, 0);
    @(negedge clk);
    op = SW; value1 = 32'h400; imm = 0; value2 = 32'hAABB_CCDD; des = 3'd6;
    @(posedge clk); #1;
    op = NOP;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_value("rst_mid_wr", mem_wr, 0);
    check_value("rst_mid_des", result_des, 0);
    check_value("rst_mid_ready", ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    mdl[17'h400] = 8'hDD;
    mdl[17'h401] = 8'hCC;
    check_value("rst_byte2_kept", ram[17'h402], 8'h33);
    check_value("rst_byte3_kept", ram[17'h403], 8'h44);
    run_op(LW, 32'h400, 0, 0, 3'd2, 0, 0);
    check_value("rst_reload", result_data, 32'h4433_CCDD);

    // address wrap at 2^17
    run_op(SB, 32'h1FFFF, 32'h34, 0, 3'd1, 0, 0);
    run_op(SB, 32'h0, 32'h12, 0, 3'd1, 0, 0);
    run_op(LH, 32'hFFFF_FFFF, 0, 0, 3'd4, 0, 0);
    check_value("wrap_const", result_data, 32'h0000_1234);

    // op presented while busy is dropped
    run_op(LW, 32'h1FC, 0, 0, 3'd3, 0, 1);
    idle_op(5'b00011);
    idle_op(NOP);

    // randomized traffic in a pre-filled window
    for (int i = 0; i < 64; i++)
      run_op(SW, 32'h1000 + 32'(4 * i), $urandom, 0, 3'($urandom_range(0, 7)), 0, 0);
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
        idle_op(5'($urandom_range(0, 17)));
      end else begin
        ro = 5'($urandom_range(18, 25));
        run_op(ro, 32'h1020 + 32'($urandom_range(0, 180)), $urandom,
               32'($urandom_range(0, 40)) - 32'd20, 3'($urandom_range(0, 7)),
               (sel == 1) ? 1 : 0, sel == 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
